// File: rtl/ldl_cdc_rx_qual_v1_if.sv
// Output-side bundle of the CDC receive qualifier: holding-buffer handshake plus change strobe.
// drop_cnt exists only when LDL_CDC_RX_QUAL_DROP_CNT_EN is defined.
interface ldl_cdc_rx_qual_v1_if #(
  parameter int DW  = 8,
  parameter int DCW = 8
);
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          changed;
`ifdef LDL_CDC_RX_QUAL_DROP_CNT_EN
  logic [DCW-1:0] drop_cnt;
`endif

  modport master (
    output out_valid,
    output out_data,
    output changed,
`ifdef LDL_CDC_RX_QUAL_DROP_CNT_EN
    output drop_cnt,
`endif
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  changed,
`ifdef LDL_CDC_RX_QUAL_DROP_CNT_EN
    input  drop_cnt,
`endif
    output out_ready
  );
endinterface

// File: rtl/ldl_cdc_rx_qual_v1.sv
// Run-length qualifier for CDC receive data feeding a one-entry, newest-wins holding buffer.
// Define LDL_CDC_RX_QUAL_DROP_CNT_EN to add the saturating overwritten-update counter (drop_cnt).
module ldl_cdc_rx_qual_v1 #(
  parameter int DW  = 8,
  parameter int SW  = 4,
  parameter int DCW = 8
) (
  input  logic                 rx_clk,
  input  logic                 rx_rst,
  input  logic [SW-1:0]        stable_len,
  input  logic [DW-1:0]        din,
  ldl_cdc_rx_qual_v1_if.master bus
);

  localparam logic [SW-1:0] RunMax = {SW{1'b1}};

  logic [DW-1:0] prev;
  logic [SW-1:0] rl;
  logic [DW-1:0] acc;
  logic          acc_vld;
  logic          out_valid_q;
  logic [DW-1:0] out_data_q;
  logic          changed_q;

  logic          same;
  logic [SW-1:0] run;
  logic [SW-1:0] target;
  logic          qualify;
  logic          load;

  // A saturated run repeats run==rl with identical data; that must not re-qualify.
  always_comb begin
    same    = (din == prev);
    target  = (stable_len == '0) ? SW'(1) : stable_len;
    run     = SW'(1);
    if (same) begin
      run = (rl == RunMax) ? RunMax : rl + SW'(1);
    end
    qualify = (run == target) && !(same && (rl == run));
    load    = qualify && (!acc_vld || (din != acc));
  end

  always_ff @(posedge rx_clk) begin
    if (!rx_rst) begin
      prev        <= '0;
      rl          <= '0;
      acc         <= '0;
      acc_vld     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      changed_q   <= 1'b0;
    end else begin
      prev      <= din;
      rl        <= run;
      changed_q <= load;
      if (qualify) begin
        acc_vld <= 1'b1;
      end
      // A load always wins over a completing handshake, so the buffer stays full.
      if (load) begin
        acc         <= din;
        out_data_q  <= din;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.changed   = changed_q;

`ifdef LDL_CDC_RX_QUAL_DROP_CNT_EN
  logic [DCW-1:0] drop_q;

  // Counts loads that overwrite an unconsumed entry; sticks at all-ones.
  always_ff @(posedge rx_clk) begin
    if (!rx_rst) begin
      drop_q <= '0;
    end else if (load && out_valid_q && !bus.out_ready && (drop_q != {DCW{1'b1}})) begin
      drop_q <= drop_q + DCW'(1);
    end
  end

  assign bus.drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_ldl_cdc_rx_qual_v1.sv
// Self-checking bench for ldl_cdc_rx_qual_v1: directed vector table, corner sequences, random vs run-length model.
// drop_cnt checks are active when LDL_CDC_RX_QUAL_DROP_CNT_EN is defined.
module tb_ldl_cdc_rx_qual_v1;

  localparam int DW       = 8;
  localparam int SW       = 4;
  localparam int DCW      = 8;
  localparam int DROP_MAX = (1 << DCW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [SW-1:0] len;
  logic [DW-1:0] din_v;
  logic          rdy;

  int n_checks = 0;
  int n_fail   = 0;

  ldl_cdc_rx_qual_v1_if #(.DW(DW), .DCW(DCW)) bus();
  assign bus.out_ready = rdy;

  ldl_cdc_rx_qual_v1 #(.DW(DW), .SW(SW), .DCW(DCW)) dut (
    .rx_clk     (clk),
    .rx_rst     (rst_n),
    .stable_len (len),
    .din        (din_v),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Reference model: unbounded length of the current run of identical samples.
  int            m_n;
  logic [DW-1:0] m_last;
  bit            m_has;
  logic [DW-1:0] m_acc;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_changed;
  int            m_drop;

  task automatic modelStep();
    int tgt;
    bit qual, ld;
    if (!rst_n) begin
      m_n = 0; m_last = '0; m_has = 0; m_acc = '0;
      m_valid = 0; m_data = '0; m_changed = 0; m_drop = 0;
      return;
    end
    m_n    = (din_v == m_last) ? m_n + 1 : 1;
    m_last = din_v;
    tgt    = (len == 0) ? 1 : int'(len);
    qual   = (m_n == tgt);
    ld     = qual && (!m_has || din_v != m_acc);
    if (qual) m_has = 1;
    if (ld) m_acc = din_v;
    m_changed = ld;
    if (ld) begin
      if (m_valid && !rdy && m_drop < DROP_MAX) m_drop++;
      m_valid = 1;
      m_data  = din_v;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [SW-1:0] l, input logic [DW-1:0] d, input logic y);
    rst_n = r;
    len   = l;
    din_v = d;
    rdy   = y;
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic [DW-1:0] ed,
                             input logic ec, input int edrop);
    n_checks++;
    if (bus.out_valid !== ev) begin
      n_fail++;
      $display("[TB] FAIL %s out_valid got %0b want %0b", name, bus.out_valid, ev);
    end
    n_checks++;
    if (bus.out_data !== ed) begin
      n_fail++;
      $display("[TB] FAIL %s out_data got %02h want %02h", name, bus.out_data, ed);
    end
    n_checks++;
    if (bus.changed !== ec) begin
      n_fail++;
      $display("[TB] FAIL %s changed got %0b want %0b", name, bus.changed, ec);
    end
`ifdef LDL_CDC_RX_QUAL_DROP_CNT_EN
    n_checks++;
    if (int'(bus.drop_cnt) != edrop) begin
      n_fail++;
      $display("[TB] FAIL %s drop_cnt got %0d want %0d", name, bus.drop_cnt, edrop);
    end
`else
    if (edrop < 0) $display("[TB] note: negative drop expectation in %s", name);
`endif
  endtask

  typedef struct {
    logic          rst;
    logic [SW-1:0] len;
    logic [DW-1:0] din;
    logic          rdy;
    logic          ev;
    logic [DW-1:0] ed;
    logic          ec;
  } vec_t;

  vec_t vecs[17];

  initial begin
    logic [DW-1:0] pool [4];
    int pulses;
    logic [DW-1:0] d;

    // {rst, stable_len, din, ready, exp valid, exp data, exp changed}
    vecs[0]  = '{1'b0, 4'd3, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 4'd3, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 4'd3, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[3]  = '{1'b1, 4'd3, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1};
    vecs[4]  = '{1'b1, 4'd3, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0};
    vecs[5]  = '{1'b1, 4'd2, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[6]  = '{1'b1, 4'd2, 8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1};
    vecs[7]  = '{1'b1, 4'd2, 8'h5A, 1'b1, 1'b0, 8'h5A, 1'b0};
    vecs[8]  = '{1'b1, 4'd2, 8'h33, 1'b1, 1'b0, 8'h5A, 1'b0};
    vecs[9]  = '{1'b1, 4'd2, 8'h5A, 1'b1, 1'b0, 8'h5A, 1'b0};
    vecs[10] = '{1'b1, 4'd2, 8'h5A, 1'b1, 1'b0, 8'h5A, 1'b0};
    vecs[11] = '{1'b1, 4'd2, 8'h5A, 1'b1, 1'b0, 8'h5A, 1'b0};
    vecs[12] = '{1'b1, 4'd0, 8'h77, 1'b0, 1'b1, 8'h77, 1'b1};
    vecs[13] = '{1'b1, 4'd0, 8'h77, 1'b0, 1'b1, 8'h77, 1'b0};
    vecs[14] = '{1'b0, 4'd0, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[15] = '{1'b1, 4'd0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1};
    vecs[16] = '{1'b1, 4'd0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};

    applyStimulus(1'b0, 4'd3, 8'h00, 1'b0);
    tick();
    tick();

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].len, vecs[i].din, vecs[i].rdy);
      tick();
      checkOutput($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].ec, 0);
    end

    // Overwrites while the consumer stalls, one load+handshake, then drop saturation.
    applyStimulus(1'b0, 4'd1, 8'h00, 1'b0);
    tick();
    checkOutput("drop_reset", 1'b0, 8'h00, 1'b0, 0);
    applyStimulus(1'b1, 4'd1, 8'h11, 1'b0);
    tick();
    checkOutput("drop_first", 1'b1, 8'h11, 1'b1, 0);
    applyStimulus(1'b1, 4'd1, 8'h22, 1'b0);
    tick();
    checkOutput("drop_one", 1'b1, 8'h22, 1'b1, 1);
    applyStimulus(1'b1, 4'd1, 8'h33, 1'b1);
    tick();
    checkOutput("load_hs", 1'b1, 8'h33, 1'b1, 1);
    for (int i = 0; i < 300; i++) begin
      d = (i % 2 == 1) ? 8'h22 : 8'h11;
      applyStimulus(1'b1, 4'd1, d, 1'b0);
      tick();
      checkOutput($sformatf("drop_sat%0d", i), 1'b1, d, 1'b1, (i + 2 > DROP_MAX) ? DROP_MAX : i + 2);
    end
    applyStimulus(1'b1, 4'd1, 8'h22, 1'b1);
    tick();
    checkOutput("drain", 1'b0, 8'h22, 1'b0, DROP_MAX);

    // Long hold at the maximum run length, then a lowered threshold mid-run.
    applyStimulus(1'b0, 4'd15, 8'h99, 1'b1);
    tick();
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 4'd15, 8'h99, 1'b1);
      tick();
      if (bus.changed === 1'b1) pulses++;
      checkOutput($sformatf("hold%0d", k), k == 14, (k >= 14) ? 8'h99 : 8'h00, k == 14, 0);
    end
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 4'd3, 8'h99, 1'b1);
      tick();
      if (bus.changed === 1'b1) pulses++;
      checkOutput($sformatf("lowered%0d", k), 1'b0, 8'h99, 1'b0, 0);
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("[TB] FAIL single_pulse count got %0d want 1", pulses);
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 4'd3, 8'h98, 1'b1);
      tick();
      checkOutput($sformatf("relaunch%0d", k), k == 2, (k == 2) ? 8'h98 : 8'h99, k == 2, 0);
    end

    // Randomized traffic against the run-length model.
    pool[0] = 8'h00; pool[1] = 8'h5A; pool[2] = 8'h33; pool[3] = 8'hFF;
    applyStimulus(1'b0, 4'd2, 8'h00, 1'b0);
    tick();
    checkOutput("rand_reset", m_valid, m_data, m_changed, m_drop);
    for (int c = 0; c < 3000; c++) begin
      logic r;
      logic [SW-1:0] l;
      r = ($urandom_range(0, 299) != 0);
      l = len;
      if ($urandom_range(0, 39) == 0)
        l = ($urandom_range(0, 9) == 0) ? 4'd15 : SW'($urandom_range(0, 5));
      d = din_v;
      if ($urandom_range(0, 9) < 3) d = pool[$urandom_range(0, 3)];
      applyStimulus(r, l, d, logic'($urandom_range(0, 1)));
      tick();
      checkOutput($sformatf("rand%0d", c), m_valid, m_data, m_changed, m_drop);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
